updown_counter: RTL and testbench

//  Parametrised successor to the basic load/run counter: modulo-MAX_COUNT up/down counter

---
 rtl/updown_counter_pkg.sv | 36 +++
 rtl/updown_counter_delay_line.sv | 35 +++
 rtl/updown_counter.sv | 136 +++++++++++++
 tb/tb_updown_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter: end-of-range modes, FSM
// encodings, the flag payload carried down the output delay line and the
// width helper used to size the count.
package updown_counter_pkg;

    // End-of-range behaviour selected by the MODE parameter
    localparam int unsigned MODE_WRAP    = 0;
    localparam int unsigned MODE_SAT     = 1;
    localparam int unsigned MODE_ONESHOT = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Per-step status flags, travelling alongside the count
    typedef struct packed {
        logic tc;
        logic wrap;
        logic done;
    } flags_t;

    // Bits needed to hold 0..max_count-1 (never less than 1)
    function automatic int unsigned log2(input int unsigned max_count);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(max_count)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/updown_counter_delay_line.sv
// DEPTH-stage register pipe with async active-low clear; DEPTH = 0 is a wire.
// Ports: clk, rst_n (active-low async clear), d_i (input word), q_o (delayed word).
module updown_counter_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];

        // Shift register; stage 0 takes the input
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/updown_counter.sv
// Modulo-MAX_COUNT up/down counter with programmable step and wrap,
// saturate or one-shot end-of-range behaviour.
// Ports:
//   clk, rst (async, active-low)
//   load/dataIn : synchronous load (clamped to MAX_COUNT-1), beats run
//   run/dir/step: advance by min(step, MAX_COUNT-1) up (dir=1) or down
//   count, tc, wrap, done : registered results, 1 + DELAY cycles after sampling
//   busy        : FSM in RUN, registered straight off the FSM (not delayed)
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned MAX_COUNT  = 32,
    parameter int unsigned BIT_WIDTH  = log2(MAX_COUNT),
    parameter int unsigned STEP_WIDTH = BIT_WIDTH,
    parameter int unsigned MODE       = MODE_WRAP,
    parameter int unsigned DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic                  dir,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [BIT_WIDTH-1:0]  dataIn,
    output logic [BIT_WIDTH-1:0]  count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  done,
    output logic                  busy
);

    // One spare bit so count + step never overflows before range checks
    localparam int unsigned SUM_W = BIT_WIDTH + 1;
    localparam int unsigned PIPE_W = BIT_WIDTH + 3;
    localparam logic [SUM_W-1:0] LAST = SUM_W'(MAX_COUNT - 1);
    localparam logic [SUM_W-1:0] MODV = SUM_W'(MAX_COUNT);

    state_e                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   count_q, count_d;
    flags_t                 flags_q, flags_d;
    logic                   busy_q;

    logic [SUM_W-1:0]       s_ext;
    logic [SUM_W-1:0]       cnt_ext;
    logic [SUM_W-1:0]       din_ext;
    logic [SUM_W-1:0]       sum_up;
    logic [SUM_W-1:0]       res;

    logic [PIPE_W-1:0]      pipe_d, pipe_q;

    // Core state, count and per-step flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flags_q <= flags_d;
            busy_q  <= (state_d == S_RUN);
        end
    end

    // Next-state, step arithmetic and flag generation
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flags_d = '0;
        cnt_ext = SUM_W'(count_q);
        din_ext = SUM_W'(dataIn);
        s_ext   = SUM_W'(step);
        if (s_ext > LAST) begin
            s_ext = LAST;
        end
        sum_up  = cnt_ext + s_ext;
        res     = cnt_ext;

        if (load) begin
            state_d = S_IDLE;
            count_d = BIT_WIDTH'((din_ext > LAST) ? LAST : din_ext);
        end else if (run && (state_q != S_DONE)) begin
            if (state_q == S_IDLE) begin
                state_d = S_RUN;
            end
            // A zero step holds the count and raises no flags
            if (s_ext != '0) begin
                if (dir) begin
                    if (sum_up <= LAST) begin
                        res = sum_up;
                    end else if (MODE == MODE_WRAP) begin
                        res          = sum_up - MODV;
                        flags_d.wrap = 1'b1;
                    end else begin
                        res = LAST;
                    end
                    flags_d.tc = (res == LAST);
                end else begin
                    if (cnt_ext >= s_ext) begin
                        res = cnt_ext - s_ext;
                    end else if (MODE == MODE_WRAP) begin
                        res          = cnt_ext + MODV - s_ext;
                        flags_d.wrap = 1'b1;
                    end else begin
                        res = '0;
                    end
                    flags_d.tc = (res == '0);
                end
                count_d = BIT_WIDTH'(res);
                if ((MODE == MODE_ONESHOT) && flags_d.tc) begin
                    state_d = S_DONE;
                end
            end
        end

        flags_d.done = (state_d == S_DONE);
    end

    // Output register plus DELAY extra stages on count and flags
    assign pipe_d = {count_q, flags_q};

    updown_counter_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (DELAY + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (pipe_d),
        .q_o   (pipe_q)
    );

    assign {count, tc, wrap, done} = pipe_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter across four parameter sets:
//   0: MAX 10 wrap, 1: MAX 10 saturate, 2: MAX 16 one-shot, 3: MAX 10 wrap DELAY 2.
module tb_updown_counter;

    localparam int unsigned N = 4;
    localparam int unsigned MAXC [N] = '{10, 10, 16, 10};
    localparam int unsigned MD   [N] = '{0, 1, 2, 0};
    localparam int unsigned DLY  [N] = '{0, 0, 0, 2};

    typedef struct packed {
        logic [3:0] c;
        logic       tc;
        logic       wr;
        logic       dn;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ld  [N];
    logic       rn  [N];
    logic       dr  [N];
    logic [3:0] st  [N];
    logic [3:0] din [N];
    logic [3:0] cnt [N];
    logic       tco [N];
    logic       wro [N];
    logic       dno [N];
    logic       bso [N];

    logic       iss  [N];
    logic [7:0] hist [N];
    exp_t       exp_q [N][$];
    logic       bsy_q [N][$];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        updown_counter #(
            .MAX_COUNT (MAXC[g]),
            .MODE      (MD[g]),
            .DELAY     (DLY[g])
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .load   (ld[g]),
            .run    (rn[g]),
            .dir    (dr[g]),
            .step   (st[g]),
            .dataIn (din[g]),
            .count  (cnt[g]),
            .tc     (tco[g]),
            .wrap   (wro[g]),
            .done   (dno[g]),
            .busy   (bso[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t: got %0d, expected %0d", nm, g, $time, act, exp);
        end
    endtask

    // Token history: bit k set means a vector was sampled k edges ago
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            hist[g] <= {hist[g][6:0], iss[g]};
        end
    end

    // Monitor: busy appears one edge after sampling, the rest 1+DELAY later
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (hist[g][0]) begin
                if (bsy_q[g].size() == 0) chk("busy_underflow", g, 1, 0);
                else chk("busy", g, int'(bso[g]), int'(bsy_q[g].pop_front()));
            end
            if (hist[g][1 + DLY[g]]) begin
                if (exp_q[g].size() == 0) begin
                    chk("sb_underflow", g, 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q[g].pop_front();
                    chk("count", g, int'(cnt[g]), int'(e.c));
                    chk("tc",    g, int'(tco[g]), int'(e.tc));
                    chk("wrap",  g, int'(wro[g]), int'(e.wr));
                    chk("done",  g, int'(dno[g]), int'(e.dn));
                end
            end
        end
    end

    // One vector on instance g, with the values expected once it takes effect
    task automatic issue(input int g, input logic l, input logic r, input logic d,
                         input logic [3:0] s, input logic [3:0] di,
                         input logic [3:0] ec, input logic et, input logic ew,
                         input logic ed, input logic eb);
        exp_t e;
        @(negedge clk);
        ld[g] = l; rn[g] = r; dr[g] = d; st[g] = s; din[g] = di;
        iss[g] = 1'b1;
        e = '{c: ec, tc: et, wr: ew, dn: ed};
        exp_q[g].push_back(e);
        bsy_q[g].push_back(eb);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            ld[g] = 1'b0; rn[g] = 1'b0; iss[g] = 1'b0;
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wrap_seq(input int g);
        issue(g, 0, 1, 1, 3, 0, 3, 0, 0, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 6, 0, 0, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 9, 1, 0, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 2, 0, 1, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 5, 0, 0, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 8, 0, 0, 0, 1);
        issue(g, 0, 1, 1, 3, 0, 1, 0, 1, 0, 1);
        issue(g, 0, 0, 1, 3, 0, 1, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            ld[g] = 0; rn[g] = 0; dr[g] = 0; st[g] = 0; din[g] = 0;
            iss[g] = 0; hist[g] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("rst_count", g, int'(cnt[g]), 0);
            chk("rst_busy",  g, int'(bso[g]), 0);
        end
        rst = 1'b1;
        idle(2);

        // Wrap mode, step 3 up from 0, then a down-step wrap and reload
        wrap_seq(0);
        issue(0, 0, 1, 0, 3, 0, 8, 0, 1, 0, 1);
        issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Load beats run and clamps; step 0 holds; oversize step clamps to 9
        issue(0, 1, 1, 1, 3, 13, 9, 0, 0, 0, 0);
        issue(0, 0, 1, 1, 0, 0, 9, 0, 0, 0, 1);
        issue(0, 0, 1, 1, 15, 0, 8, 0, 1, 0, 1);
        issue(0, 0, 1, 1, 1, 0, 9, 1, 0, 0, 1);
        issue(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1);
        issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Saturate mode: repeated tc at both ends
        issue(1, 1, 0, 1, 0, 8, 8, 0, 0, 0, 0);
        issue(1, 0, 1, 1, 4, 0, 9, 1, 0, 0, 1);
        issue(1, 0, 1, 1, 4, 0, 9, 1, 0, 0, 1);
        issue(1, 0, 1, 0, 4, 0, 5, 0, 0, 0, 1);
        issue(1, 0, 1, 0, 4, 0, 1, 0, 0, 0, 1);
        issue(1, 0, 1, 0, 4, 0, 0, 1, 0, 0, 1);
        issue(1, 0, 1, 0, 4, 0, 0, 1, 0, 0, 1);
        issue(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);

        // One-shot: stop at 15, ignore run, reload clears done
        issue(2, 0, 1, 1, 5, 0, 5, 0, 0, 0, 1);
        issue(2, 0, 1, 1, 5, 0, 10, 0, 0, 0, 1);
        issue(2, 0, 1, 1, 5, 0, 15, 1, 0, 1, 0);
        issue(2, 0, 1, 1, 5, 0, 15, 0, 0, 1, 0);
        issue(2, 0, 1, 0, 5, 0, 15, 0, 0, 1, 0);
        issue(2, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        idle(4);

        // Same wrap sequence through two extra output stages
        wrap_seq(3);
        idle(6);

        // Async reset dropped between edges while instance 0 runs
        @(negedge clk);
        rn[0] = 1'b1; dr[0] = 1'b1; st[0] = 4'd3;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("arst_count", g, int'(cnt[g]), 0);
            chk("arst_flags", g, int'({tco[g], wro[g], dno[g]}), 0);
            chk("arst_busy",  g, int'(bso[g]), 0);
        end
        @(negedge clk);
        rn[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rel_count", 0, int'(cnt[0]), 0);
        chk("post_rel_busy",  0, int'(bso[0]), 0);
        issue(0, 0, 1, 1, 3, 0, 3, 0, 0, 0, 1);
        issue(0, 0, 0, 1, 3, 0, 3, 0, 0, 0, 1);
        idle(8);

        for (int g = 0; g < N; g++) begin
            chk("sb_drain", g, exp_q[g].size() + bsy_q[g].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
